dmux_tag_retire: RTL and testbench

Retirement stage directly downstream of the EU-side data multiplexer. It consumes the merged, tagged 64-bit response stream (DRDY/TAG/DATA) and checks every returning tag against a scoreboard of outstanding requests. Valid responses are forwarded as one-cycle register-file writes and the tag is freed. The block also tracks the outstanding count, flags orphan (unrequested) responses and raises a watchdog timeout when responses stop arriving.

---
 rtl/dmux_tag_retire.sv | 104 ++++++++++
 tb/tb_dmux_tag_retire.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmux_tag_retire.sv
// rtl/dmux_tag_retire.sv - tag scoreboard retirement stage behind the EU data multiplexer
module dmux_tag_retire #(
   parameter int TagWidth      = 11,
   parameter int TimeoutCycles = 1024
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                DRDY,
   input  logic [TagWidth-1:0] TAG,
   input  logic [63:0]         DATA,
   input  logic                IssueValid,
   input  logic [TagWidth-1:0] IssueTag,
   output logic                IssueBusy,
   input  logic                Flush,
   input  logic                ErrClr,
   output logic                WE,
   output logic [TagWidth-1:0] WTAG,
   output logic [63:0]         WDATA,
   output logic [TagWidth:0]   Outstanding,
   output logic                Idle,
   output logic                OrphanErr,
   output logic [TagWidth-1:0] OrphanTag,
   output logic                Timeout
);

   localparam int Depth   = 1 << TagWidth;
   localparam int WdWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

   logic [Depth-1:0]   pending;
   logic [WdWidth-1:0] wd_cnt;
   logic               retire;
   logic               orphan;
   logic               issue_acc;
   logic               wd_expire;

   // A retire of the same tag in this cycle frees the slot, so the issue may reuse it.
   assign IssueBusy = pending[IssueTag] & ~(DRDY & (TAG == IssueTag));
   assign retire    = DRDY & pending[TAG];
   assign orphan    = DRDY & ~pending[TAG];
   assign issue_acc = IssueValid & ~IssueBusy & ~Flush;
   assign Idle      = (Outstanding == '0);
   assign wd_expire = (wd_cnt == WdWidth'(TimeoutCycles - 1));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         pending     <= '0;
         Outstanding <= '0;
         WE          <= 1'b0;
         WTAG        <= '0;
         WDATA       <= '0;
      end else begin
         WE <= retire;
         if (retire) begin
            WTAG  <= TAG;
            WDATA <= DATA;
         end
         if (Flush) begin
            pending     <= '0;
            Outstanding <= '0;
         end else begin
            // Clear before set: a same-tag retire+issue leaves the slot pending.
            if (retire)
               pending[TAG] <= 1'b0;
            if (issue_acc)
               pending[IssueTag] <= 1'b1;
            Outstanding <= Outstanding + (TagWidth+1)'(issue_acc) - (TagWidth+1)'(retire);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         OrphanErr <= 1'b0;
         OrphanTag <= '0;
      end else if (orphan) begin
         OrphanErr <= 1'b1;
         if (!OrphanErr)
            OrphanTag <= TAG;
      end else if (ErrClr) begin
         OrphanErr <= 1'b0;
      end
   end

   // Watchdog saturates at its terminal count and keeps re-asserting Timeout.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wd_cnt  <= '0;
         Timeout <= 1'b0;
      end else begin
         if (retire || Flush || Idle) begin
            wd_cnt <= '0;
            if (ErrClr)
               Timeout <= 1'b0;
         end else if (wd_expire) begin
            Timeout <= 1'b1;
         end else begin
            wd_cnt <= wd_cnt + WdWidth'(1);
            if (ErrClr)
               Timeout <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dmux_tag_retire.sv
// tb/tb_dmux_tag_retire.sv - directed table, hand sequences and randomized model check for dmux_tag_retire
module tb_dmux_tag_retire;

   localparam int TW = 6;
   localparam int TO = 16;
   localparam int NT = 1 << TW;

   logic          CLK = 1'b0;
   logic          RESET, DRDY, IssueValid, Flush, ErrClr;
   logic [TW-1:0] TAG, IssueTag;
   logic [63:0]   DATA;
   logic          IssueBusy, WE, Idle, OrphanErr, Timeout;
   logic [TW-1:0] WTAG, OrphanTag;
   logic [63:0]   WDATA;
   logic [TW:0]   Outstanding;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   dmux_tag_retire #(.TagWidth(TW), .TimeoutCycles(TO)) dut (
      .CLK(CLK), .RESET(RESET), .DRDY(DRDY), .TAG(TAG), .DATA(DATA),
      .IssueValid(IssueValid), .IssueTag(IssueTag), .IssueBusy(IssueBusy),
      .Flush(Flush), .ErrClr(ErrClr), .WE(WE), .WTAG(WTAG), .WDATA(WDATA),
      .Outstanding(Outstanding), .Idle(Idle), .OrphanErr(OrphanErr),
      .OrphanTag(OrphanTag), .Timeout(Timeout)
   );

   // Reference model: set of pending tags, last response, sticky flags, and the
   // edge index of the most recent event that restarts the watchdog.
   bit          m_pend[NT];
   bit          m_we;
   int          m_wtag;
   logic [63:0] m_wdata;
   bit          m_oerr;
   int          m_otag;
   bit          m_tout;
   int          cyc = 0;
   int          last_ev = 0;

   function automatic int m_count();
      int c = 0;
      foreach (m_pend[i]) c += m_pend[i];
      return c;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_edge();
      bit was_idle, hit, busy, acc, tset;
      was_idle = (m_count() == 0);
      cyc++;
      if (RESET) begin
         foreach (m_pend[i]) m_pend[i] = 0;
         m_we = 0; m_wtag = 0; m_wdata = '0;
         m_oerr = 0; m_otag = 0; m_tout = 0;
         last_ev = cyc;
         return;
      end
      hit  = DRDY && m_pend[TAG];
      busy = m_pend[IssueTag] && !(DRDY && TAG == IssueTag);
      acc  = IssueValid && !busy && !Flush;
      m_we = hit;
      if (hit) begin
         m_wtag  = int'(TAG);
         m_wdata = DATA;
         m_pend[TAG] = 0;
      end
      if (Flush) foreach (m_pend[i]) m_pend[i] = 0;
      if (acc) m_pend[IssueTag] = 1;
      if (DRDY && !hit) begin
         if (!m_oerr) m_otag = int'(TAG);
         m_oerr = 1;
      end else if (ErrClr) begin
         m_oerr = 0;
      end
      tset = 0;
      if (hit || Flush || was_idle) last_ev = cyc;
      else if (cyc - last_ev >= TO) tset = 1;
      if (tset) m_tout = 1;
      else if (ErrClr) m_tout = 0;
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      check("we", WE, m_we);
      if (m_we) begin
         check("wtag", WTAG, m_wtag);
         check("wdata", WDATA, m_wdata);
      end
      check("outstanding", Outstanding, m_count());
      check("idle", Idle, m_count() == 0);
      check("orphan_err", OrphanErr, m_oerr);
      check("orphan_tag", OrphanTag, m_otag);
      check("timeout", Timeout, m_tout);
   endtask

   task automatic cyc_in(input int rst, input int drdy, input int tag, input logic [63:0] data,
                         input int iv, input int itag, input int fl, input int ec);
      RESET = rst[0]; DRDY = drdy[0]; TAG = tag[TW-1:0]; DATA = data;
      IssueValid = iv[0]; IssueTag = itag[TW-1:0]; Flush = fl[0]; ErrClr = ec[0];
      #1;
      if (!RESET)
         check("issue_busy", IssueBusy, m_pend[IssueTag] && !(DRDY && TAG == IssueTag));
      step();
   endtask

   typedef struct {
      int rst, drdy, tag, iv, itag, fl, ec;
      int e_we, e_wtag, e_out, e_oerr, e_otag;   // -1 = don't care
   } vec_t;

   vec_t tbl[$];
   int   q[$];
   int   pct;
   logic [63:0] d;

   initial begin
      RESET = 1'b1; DRDY = 1'b0; TAG = '0; DATA = '0;
      IssueValid = 1'b0; IssueTag = '0; Flush = 1'b0; ErrClr = 1'b0;
      repeat (2) step();

      //            rst drdy tag iv itag fl ec  we wtag out oerr otag
      tbl.push_back('{1, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 1, 5, 0, 0,   0, -1, 1, 0, -1});
      tbl.push_back('{0, 0, 0, 1, 6, 0, 0,   0, -1, 2, 0, -1});
      tbl.push_back('{0, 0, 0, 1, 7, 0, 0,   0, -1, 3, 0, -1});
      tbl.push_back('{0, 1, 6, 0, 0, 0, 0,   1,  6, 2, 0, -1});
      tbl.push_back('{0, 1, 5, 0, 0, 0, 0,   1,  5, 1, 0, -1});
      tbl.push_back('{0, 1, 7, 0, 0, 0, 0,   1,  7, 0, 0, -1});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 0,   0, -1, 0, 0, -1});
      tbl.push_back('{0, 1, 9, 0, 0, 0, 0,   0, -1, 0, 1, 9});
      tbl.push_back('{0, 1, 3, 0, 0, 0, 0,   0, -1, 0, 1, 9});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1,   0, -1, 0, 0, -1});
      tbl.push_back('{0, 0, 0, 1, 12, 0, 0,  0, -1, 1, 0, -1});
      tbl.push_back('{0, 0, 0, 1, 12, 0, 0,  0, -1, 1, 0, -1});
      tbl.push_back('{0, 1, 12, 1, 12, 0, 0, 1, 12, 1, 0, -1});
      tbl.push_back('{0, 1, 12, 0, 0, 0, 0,  1, 12, 0, 0, -1});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 0,   0, -1, 0, 0, -1});

      foreach (tbl[i]) begin
         cyc_in(tbl[i].rst, tbl[i].drdy, tbl[i].tag, 64'hD000 + 64'(tbl[i].tag),
                tbl[i].iv, tbl[i].itag, tbl[i].fl, tbl[i].ec);
         if (tbl[i].e_we >= 0) check("tbl_we", WE, tbl[i].e_we);
         if (tbl[i].e_we == 1) begin
            check("tbl_wtag", WTAG, tbl[i].e_wtag);
            check("tbl_wdata", WDATA, 64'hD000 + 64'(tbl[i].e_wtag));
         end
         if (tbl[i].e_out >= 0) check("tbl_out", Outstanding, tbl[i].e_out);
         if (tbl[i].e_oerr >= 0) check("tbl_oerr", OrphanErr, tbl[i].e_oerr);
         if (tbl[i].e_otag >= 0) check("tbl_otag", OrphanTag, tbl[i].e_otag);
      end

      // Flush with 32 outstanding, then a response to a flushed tag is an orphan.
      for (int t = 0; t < 32; t++) cyc_in(0, 0, 0, 0, 1, t, 0, 0);
      check("flush_pre_out", Outstanding, 32);
      cyc_in(0, 0, 0, 0, 0, 0, 1, 0);
      check("flush_out", Outstanding, 0);
      check("flush_idle", Idle, 1);
      cyc_in(0, 1, 4, 64'h44, 0, 0, 0, 0);
      check("flush_we", WE, 0);
      check("flush_oerr", OrphanErr, 1);
      check("flush_otag", OrphanTag, 4);

      // Watchdog: one outstanding tag and no response.
      cyc_in(0, 0, 0, 0, 0, 0, 0, 1);
      check("wd_clr", Timeout, 0);
      cyc_in(0, 0, 0, 0, 1, 1, 0, 0);
      for (int k = 1; k <= TO; k++) begin
         cyc_in(0, 0, 0, 0, 0, 0, 0, 0);
         if (k == TO - 1) check("wd_early", Timeout, 0);
         if (k == TO)     check("wd_fire", Timeout, 1);
      end
      cyc_in(0, 1, 1, 64'h1111, 0, 0, 0, 0);
      check("wd_ret_we", WE, 1);
      check("wd_ret_data", WDATA, 64'h1111);
      check("wd_sticky", Timeout, 1);
      cyc_in(0, 0, 0, 0, 0, 0, 0, 1);
      check("wd_errclr", Timeout, 0);

      // Reset in the middle of a response stream.
      for (int t = 20; t < 24; t++) cyc_in(0, 0, 0, 0, 1, t, 0, 0);
      cyc_in(0, 1, 20, 64'h20, 0, 0, 0, 0);
      check("rs_we", WE, 1);
      cyc_in(1, 1, 21, 64'h21, 1, 30, 1, 0);
      check("rs_we0", WE, 0);
      check("rs_wtag0", WTAG, 0);
      check("rs_wdata0", WDATA, 0);
      check("rs_out0", Outstanding, 0);
      check("rs_idle", Idle, 1);
      check("rs_oerr0", OrphanErr, 0);
      check("rs_otag0", OrphanTag, 0);
      check("rs_tout0", Timeout, 0);
      cyc_in(0, 1, 22, 64'h22, 0, 0, 0, 0);
      check("rs_orph22", OrphanErr, 1);
      check("rs_otag22", OrphanTag, 22);
      cyc_in(0, 1, 23, 64'h23, 0, 0, 0, 0);
      check("rs_we23", WE, 0);
      check("rs_otag_keep", OrphanTag, 22);

      // Randomized traffic against the model, in phases of varying response rate.
      for (int blk = 0; blk < 16; blk++) begin
         case (blk % 3)
            0: pct = 0;
            1: pct = 15;
            default: pct = 60;
         endcase
         for (int c = 0; c < 150; c++) begin
            int r_drdy, r_tag;
            q.delete();
            foreach (m_pend[i]) if (m_pend[i]) q.push_back(i);
            r_drdy = ($urandom_range(99) < pct) ? 1 : 0;
            if (q.size() > 0 && $urandom_range(9) < 8)
               r_tag = q[$urandom_range(q.size() - 1)];
            else
               r_tag = $urandom_range(NT - 1);
            d = {$urandom, $urandom};
            cyc_in(($urandom_range(499) == 0) ? 1 : 0, r_drdy, r_tag, d,
                   ($urandom_range(2) == 0) ? 1 : 0, $urandom_range(NT - 1),
                   ($urandom_range(99) == 0) ? 1 : 0,
                   ($urandom_range(29) == 0) ? 1 : 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
